// File: rtl/crypto_wallet_mem_pkg.sv
// Shared types and helpers for the wallet on-chip memory.
// Holds the controller state encoding and sizing helpers.
package crypto_wallet_mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN,
    ZERO
  } state_t;

  localparam int WORD_BITS = 32;
  localparam int BYTES = WORD_BITS / 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/crypto_wallet_tdp_ram.sv
// Byte-enabled true-dual-port RAM, old-data on mixed-port collision.
// One registered read stage per port.
module crypto_wallet_tdp_ram
  import crypto_wallet_mem_pkg::*;
#(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 8000,
  parameter int    IW        = 13,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          a_we,
  input  logic          a_re,
  input  logic [IW-1:0] a_addr,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic          b_re,
  input  logic [IW-1:0] b_addr,
  input  logic [DW/8-1:0] b_be,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (a_we && a_be[i])
          mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        if (b_we && b_be[i])
          mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (en) begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/crypto_wallet_onchip_memory_dp.sv
// Dual Avalon-MM port wallet RAM with pipelined reads
// and a zeroize sweep that clears key material.
module crypto_wallet_onchip_memory_dp
  import crypto_wallet_mem_pkg::*;
#(
  parameter int    DATA_WIDTH       = 32,
  parameter int    DEPTH            = 8000,
  parameter int    ADDR_WIDTH       = 13,
  parameter int    READ_LATENCY     = 1,
  parameter string INIT_FILE        = "",
  parameter bit    ZEROIZE_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    zeroize,
  output logic                    zeroize_busy,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic en, sweeping, hold;
  logic acc1, acc2, wr1, wr2, rd1, rd2;
  logic in1, in2, same;
  logic pipe_empty;

  logic          a_we, b_we;
  logic [CW-1:0] a_addr;
  logic [BW-1:0] a_be, b_be;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_q, b_q;

  logic p1_v1, p1_v2, p1_oor1, p1_oor2;
  logic [DATA_WIDTH-1:0] d1_1, d1_2;

  assign en       = clken & ~reset_req;
  assign sweeping = (state_q == INIT) | (state_q == ZERO);
  assign hold     = (state_q != RUN) | zeroize | ~en | reset;

  assign s1_waitrequest = hold;
  assign s2_waitrequest = hold;
  assign zeroize_busy   = (state_q != RUN) & ~reset;

  assign acc1 = s1_chipselect & (s1_read | s1_write) & ~hold;
  assign acc2 = s2_chipselect & (s2_read | s2_write) & ~hold;
  assign wr1  = acc1 & s1_write;
  assign wr2  = acc2 & s2_write;
  assign rd1  = acc1 & s1_read & ~s1_write;
  assign rd2  = acc2 & s2_read & ~s2_write;

  assign in1  = {1'b0, s1_address} < LIMIT;
  assign in2  = {1'b0, s2_address} < LIMIT;
  assign same = s1_address == s2_address;

  // Sweep borrows port a; s1 lanes win on a shared address
  always_comb begin
    a_we    = wr1 & in1;
    a_addr  = s1_address[CW-1:0];
    a_be    = s1_byteenable;
    a_wdata = s1_writedata;
    if (sweeping) begin
      a_we    = 1'b1;
      a_addr  = cnt_q;
      a_be    = '1;
      a_wdata = '0;
    end
    b_we = wr2 & in2;
    b_be = s2_byteenable
         & ~({BW{wr1 & in1 & same}} & s1_byteenable);
  end

  crypto_wallet_tdp_ram #(
    .DW        (DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IW        (CW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .en      (en),
    .a_we    (a_we),
    .a_re    (rd1),
    .a_addr  (a_addr),
    .a_be    (a_be),
    .a_wdata (a_wdata),
    .a_rdata (a_q),
    .b_we    (b_we),
    .b_re    (rd2),
    .b_addr  (s2_address[CW-1:0]),
    .b_be    (b_be),
    .b_wdata (s2_writedata),
    .b_rdata (b_q)
  );

  // First read stage: valid and out-of-range flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_v1   <= 1'b0;
      p1_v2   <= 1'b0;
      p1_oor1 <= 1'b0;
      p1_oor2 <= 1'b0;
    end else if (en) begin
      p1_v1 <= rd1;
      p1_v2 <= rd2;
      if (rd1) p1_oor1 <= ~in1;
      if (rd2) p1_oor2 <= ~in2;
    end
  end

  assign d1_1 = p1_oor1 ? '0 : a_q;
  assign d1_2 = p1_oor2 ? '0 : b_q;

  if (READ_LATENCY == 2) begin : g_rl2
    logic p2_v1, p2_v2;
    logic [DATA_WIDTH-1:0] p2_d1, p2_d2;

    // Optional output register stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        p2_v1 <= 1'b0;
        p2_v2 <= 1'b0;
        p2_d1 <= '0;
        p2_d2 <= '0;
      end else if (en) begin
        p2_v1 <= p1_v1;
        p2_v2 <= p1_v2;
        if (p1_v1) p2_d1 <= d1_1;
        if (p1_v2) p2_d2 <= d1_2;
      end
    end

    assign s1_readdata      = p2_d1;
    assign s1_readdatavalid = p2_v1;
    assign s2_readdata      = p2_d2;
    assign s2_readdatavalid = p2_v2;
    assign pipe_empty =
      ~(p1_v1 | p1_v2 | p2_v1 | p2_v2);
  end else begin : g_rl1
    assign s1_readdata      = d1_1;
    assign s1_readdatavalid = p1_v1;
    assign s2_readdata      = d1_2;
    assign s2_readdatavalid = p1_v2;
    assign pipe_empty       = ~(p1_v1 | p1_v2);
  end

  // Controller state and sweep counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ZEROIZE_ON_RESET ? INIT : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep DEPTH words, drain reads first
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        INIT, ZERO: begin
          if (cnt_q == LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN:     if (zeroize) state_d = DRAIN;
        DRAIN:   if (pipe_empty) state_d = ZERO;
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_wallet_onchip_memory_dp.sv
// Directed bench for the wallet dual-port RAM.
// DEPTH=16, READ_LATENCY=2, zeroize on reset.
module tb_crypto_wallet_onchip_memory_dp;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clken, reset_req, zeroize, zeroize_busy;
  logic [AW-1:0] s1_address, s2_address;
  logic s1_chipselect, s1_read, s1_write;
  logic s2_chipselect, s2_read, s2_write;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] s1_readdata, s2_readdata;
  logic s1_readdatavalid, s1_waitrequest;
  logic s2_readdatavalid, s2_waitrequest;

  crypto_wallet_onchip_memory_dp #(
    .DATA_WIDTH       (32),
    .DEPTH            (16),
    .ADDR_WIDTH       (AW),
    .READ_LATENCY     (2),
    .INIT_FILE        (""),
    .ZEROIZE_ON_RESET (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clken            (clken),
    .reset_req        (reset_req),
    .zeroize          (zeroize),
    .zeroize_busy     (zeroize_busy),
    .s1_address       (s1_address),
    .s1_chipselect    (s1_chipselect),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_byteenable    (s1_byteenable),
    .s1_writedata     (s1_writedata),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_chipselect    (s2_chipselect),
    .s2_read          (s2_read),
    .s2_write         (s2_write),
    .s2_byteenable    (s2_byteenable),
    .s2_writedata     (s2_writedata),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest)
  );

  typedef struct {
    bit          is_rd;
    int          port;
    int          addr;
    int          be;
    logic [31:0] data;
    string       nm;
  } vec_t;

  vec_t tbl[13];
  int checks = 0;
  int failures = 0;
  int n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input int a, input int be,
                       input logic [31:0] d);
    if (p == 1) begin
      s1_chipselect = rd | wr;
      s1_read       = rd;
      s1_write      = wr;
      s1_address    = AW'(a);
      s1_byteenable = 4'(be);
      s1_writedata  = d;
    end else begin
      s2_chipselect = rd | wr;
      s2_read       = rd;
      s2_write      = wr;
      s2_address    = AW'(a);
      s2_byteenable = 4'(be);
      s2_writedata  = d;
    end
  endtask

  task automatic idle();
    drive(1, 1'b0, 1'b0, 0, 0, 32'h0);
    drive(2, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  function automatic logic rdv(input int p);
    return (p == 1) ? s1_readdatavalid : s2_readdatavalid;
  endfunction

  function automatic logic [31:0] rdd(input int p);
    return (p == 1) ? s1_readdata : s2_readdata;
  endfunction

  function automatic logic wq(input int p);
    return (p == 1) ? s1_waitrequest : s2_waitrequest;
  endfunction

  task automatic wr(input int p, input int a, input int be,
                    input logic [31:0] d, input string nm);
    @(negedge clk);
    drive(p, 1'b0, 1'b1, a, be, d);
    chk({nm, " accept"}, 32'(wq(p)), 32'd0);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input int a,
                    input logic [31:0] e, input string nm);
    @(negedge clk);
    drive(p, 1'b1, 1'b0, a, 0, 32'h0);
    chk({nm, " accept"}, 32'(wq(p)), 32'd0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk({nm, " early"}, 32'(rdv(p)), 32'd0);
    @(negedge clk);
    chk({nm, " valid"}, 32'(rdv(p)), 32'd1);
    chk({nm, " data"}, rdd(p), e);
    @(negedge clk);
    chk({nm, " late"}, 32'(rdv(p)), 32'd0);
  endtask

  task automatic count_wait(output int c);
    c = 0;
    while (s1_waitrequest === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 1, 5,  'hF, 32'hDEADBEEF, "s1 w5"};
    tbl[1]  = '{1, 2, 5,  0,   32'hDEADBEEF, "s2 r5"};
    tbl[2]  = '{0, 2, 9,  'h3, 32'h0000CAFE, "s2 w9 lo"};
    tbl[3]  = '{1, 1, 9,  0,   32'h0000CAFE, "s1 r9 lo"};
    tbl[4]  = '{0, 1, 9,  'hC, 32'h12340000, "s1 w9 hi"};
    tbl[5]  = '{1, 2, 9,  0,   32'h1234CAFE, "s2 r9"};
    tbl[6]  = '{0, 1, 20, 'hF, 32'hFFFFFFFF, "s1 w20 oor"};
    tbl[7]  = '{1, 1, 4,  0,   32'h00000000, "s1 r4 alias"};
    tbl[8]  = '{1, 2, 20, 0,   32'h00000000, "s2 r20 oor"};
    tbl[9]  = '{0, 2, 15, 'h1, 32'h000000AB, "s2 w15 b0"};
    tbl[10] = '{1, 1, 15, 0,   32'h000000AB, "s1 r15"};
    tbl[11] = '{0, 2, 0,  'hF, 32'h0BADF00D, "s2 w0"};
    tbl[12] = '{1, 1, 0,  0,   32'h0BADF00D, "s1 r0"};

    reset = 1'b1;
    clken = 1'b1;
    reset_req = 1'b0;
    zeroize = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst wait1", 32'(s1_waitrequest), 32'd1);
    chk("rst wait2", 32'(s2_waitrequest), 32'd1);
    chk("rst busy", 32'(zeroize_busy), 32'd0);
    chk("rst rdv1", 32'(s1_readdatavalid), 32'd0);
    chk("rst rdv2", 32'(s2_readdatavalid), 32'd0);
    chk("rst rdata1", s1_readdata, 32'h0);
    reset = 1'b0;
    #1;
    count_wait(n);
    chk("init sweep len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++)
      rd((i % 2) + 1, i, 32'h0, "init zero");

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].is_rd)
        rd(tbl[i].port, tbl[i].addr, tbl[i].data, tbl[i].nm);
      else
        wr(tbl[i].port, tbl[i].addr, tbl[i].be,
           tbl[i].data, tbl[i].nm);
    end

    @(negedge clk);
    drive(1, 1'b0, 1'b1, 3, 'h3, 32'h11111111);
    drive(2, 1'b0, 1'b1, 3, 'hF, 32'h22222222);
    @(posedge clk);
    #1;
    idle();
    rd(1, 3, 32'h22221111, "ww collide");

    wr(1, 7, 'hF, 32'hA5A5A5A5, "pre7");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 7, 0, 32'h0);
    drive(2, 1'b0, 1'b1, 7, 'hF, 32'h5A5A5A5A);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("rw early", 32'(s1_readdatavalid), 32'd0);
    @(negedge clk);
    chk("rw valid", 32'(s1_readdatavalid), 32'd1);
    chk("rw old data", s1_readdata, 32'hA5A5A5A5);
    rd(2, 7, 32'h5A5A5A5A, "rw new data");

    wr(1, 0, 'hF, 32'h00000077, "pre0");
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("stall pre valid", 32'(s1_readdatavalid), 32'd1);
    clken = 1'b0;
    @(negedge clk);
    chk("stall hold valid", 32'(s1_readdatavalid), 32'd1);
    chk("stall hold data", s1_readdata, 32'h00000077);
    chk("stall wait", 32'(s1_waitrequest), 32'd1);
    clken = 1'b1;
    @(negedge clk);
    chk("stall release", 32'(s1_readdatavalid), 32'd0);

    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1, 'hF, 32'h000000FF);
    reset_req = 1'b1;
    #1;
    chk("rreq wait", 32'(s1_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    idle();
    reset_req = 1'b0;
    rd(1, 1, 32'h0, "rreq drop");

    @(negedge clk);
    drive(1, 1'b1, 1'b0, 5, 0, 32'h0);
    @(posedge clk);
    #1;
    idle();
    drive(2, 1'b1, 1'b0, 9, 0, 32'h0);
    @(negedge clk);
    chk("zq s1 early", 32'(s1_readdatavalid), 32'd0);
    @(posedge clk);
    #1;
    idle();
    zeroize = 1'b1;
    @(negedge clk);
    chk("zq s1 valid", 32'(s1_readdatavalid), 32'd1);
    chk("zq s1 data", s1_readdata, 32'hDEADBEEF);
    chk("zq busy pre", 32'(zeroize_busy), 32'd0);
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    @(negedge clk);
    chk("zq s2 valid", 32'(s2_readdatavalid), 32'd1);
    chk("zq s2 data", s2_readdata, 32'h1234CAFE);
    n = 0;
    while (zeroize_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("zq busy len", 32'(n), 32'd18);
    for (int i = 0; i < 16; i++)
      rd(2 - (i % 2), i, 32'h0, "zq cleared");

    wr(1, 12, 'hF, 32'hFFFFFFFF, "pre12");
    @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    @(negedge clk);
    n = 0;
    while (zeroize_busy && n < 200) begin
      n++;
      clken = !(n >= 6 && n < 11);
      zeroize = (n == 14);
      @(negedge clk);
    end
    zeroize = 1'b0;
    clken = 1'b1;
    chk("stall sweep len", 32'(n), 32'd22);
    rd(1, 12, 32'h0, "stall sweep clr");

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst busy", 32'(zeroize_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid busy on", 32'(zeroize_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid rst wait", 32'(s1_waitrequest), 32'd1);
    reset = 1'b0;
    #1;
    count_wait(n);
    chk("mid restart len", 32'(n), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
